// File: rtl/bcd_pkg.sv
// Shared types and elaboration-time helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    // Converter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_e;

    // Width of one packed BCD digit
    localparam int BCD_DIGIT_W = 4;

    // 10^n as a 64-bit constant; DIGITS up to 10 needs more than 32 bits
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < n; i++) begin
            v = v * 64'd10;
        end
        return v;
    endfunction

    // Bit counter width able to hold n-1, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the double-dabble correction: add 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next decimal digit.
import bcd_pkg::*;

module bcd_digit_adj (
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    // Add-3 correction ahead of the shift
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock) with
// valid/ready handshakes on both sides, held results and overflow saturation to all 9s.
// Optional leading-zero blank mask is built only when BCD_LEADING_BLANK_EN is defined;
// otherwise blank_mask is tied to zero.
import bcd_pkg::*;

module bin_to_bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [BIN_W-1:0]                numero_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_out,
    output logic                            overflow,
    output logic [DIGITS-1:0]               blank_mask
);

    localparam int          ACC_W        = BCD_DIGIT_W * DIGITS;
    localparam int          CNT_W        = cnt_w(BIN_W);
    localparam logic [63:0] MAX_VAL      = pow10(DIGITS) - 64'd1;
    localparam logic [63:0] BIN_MAX      = (64'd1 << BIN_W) - 64'd1;
    // Overflow is only reachable when the input range exceeds the decimal range
    localparam bit          OVF_POSSIBLE = (MAX_VAL < BIN_MAX);
    localparam logic [ACC_W-1:0] ALL_NINES = {DIGITS{4'h9}};
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(BIN_W - 1);

    bcd_state_e         r_state;
    logic [BIN_W-1:0]   r_bin;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_bcd_out;
    logic               r_overflow;

    logic [ACC_W-1:0]   w_adj;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_ovf_in;

    // Per-digit add-3 correction on the current accumulator
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .i_digit (r_acc[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
                .o_digit (w_adj[BCD_DIGIT_W*g +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Corrected accumulator shifted left, taking in the next binary MSB
    assign w_acc_next = {w_adj[ACC_W-2:0], r_bin[BIN_W-1]};

    // Overflow detection at load; collapses to 0 when it cannot happen
    generate
        if (OVF_POSSIBLE) begin : g_ovf
            logic [63:0] w_num_ext;
            assign w_num_ext = {{(64-BIN_W){1'b0}}, numero_in};
            assign w_ovf_in  = (w_num_ext > MAX_VAL);
        end else begin : g_no_ovf
            assign w_ovf_in = 1'b0;
        end
    endgenerate

`ifdef BCD_LEADING_BLANK_EN
    logic [DIGITS-1:0]  r_blank;
    logic [DIGITS-1:0]  w_blank;

    // Leading-zero mask of the final value; units digit never blanked
    always_comb begin
        logic w_run;
        w_blank = '0;
        w_run   = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_run      = w_run && (w_acc_next[BCD_DIGIT_W*k +: BCD_DIGIT_W] == 4'd0);
            w_blank[k] = w_run && !r_ovf;
        end
    end

    assign blank_mask = r_blank;
`else
    assign blank_mask = '0;
`endif

    // Control FSM, shift datapath and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bin       <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_bcd_out   <= '0;
            r_overflow  <= 1'b0;
`ifdef BCD_LEADING_BLANK_EN
            r_blank     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_bin      <= numero_in;
                        r_acc      <= '0;
                        r_cnt      <= CNT_LOAD;
                        r_ovf      <= w_ovf_in;
                        r_in_ready <= 1'b0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_acc <= w_acc_next;
                    r_bin <= r_bin << 1;
                    if (r_cnt == '0) begin
                        // Last bit: publish the result in the same edge
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_bcd_out   <= r_ovf ? ALL_NINES : w_acc_next;
                        r_overflow  <= r_ovf;
`ifdef BCD_LEADING_BLANK_EN
                        r_blank     <= w_blank;
`endif
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign bcd_out   = r_bcd_out;
    assign overflow  = r_overflow;

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Parametrised sequential binary-to-BCD converter using iterative shift-add-3 (double dabble), one input bit per clock.
- Generalises the fixed 16-bit, 4-digit converter to any input width and digit count.
- Adds a valid/ready handshake on both sides, held results, and overflow saturation.
- Sits between arithmetic/counter logic and the 7-segment display driver.

Parameters:
- BIN_W, 16, input binary width in bits (2..32).
- DIGITS, 5, number of BCD output digits (1..10).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  numero_in is valid.
- in_ready  output  1  block can accept a new value.
- numero_in  input  BIN_W  unsigned binary value.
- out_valid  output  1  bcd_out, overflow and blank_mask are valid.
- out_ready  input  1  consumer accepts the result.
- bcd_out  output  4*DIGITS  packed digits; digit k at [4k+3:4k]; digit 0 is units.
- overflow  output  1  input exceeded 10^DIGITS-1.
- blank_mask  output  DIGITS  bit k=1 means digit k is a leading zero (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, bcd_out=0, overflow=0, blank_mask=0, internal shift register and bit counter cleared.
- Reset mid-conversion or while results are held discards everything immediately; no partial result is ever presented.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready the block loads numero_in into the binary shift register, clears the BCD accumulator, sets bit counter=BIN_W-1 and goes to SHIFT.
  - At load, overflow_q = (numero_in > MAX_VAL), where MAX_VAL = 10^DIGITS-1 computed at elaboration. If MAX_VAL >= 2^BIN_W-1, overflow_q is constant 0.
- SHIFT:
  - in_ready=0; in_valid is ignored and not queued.
  - Each cycle: every BCD digit >=5 gets +3 (combinational), then the concatenation {bcd, bin} shifts left by 1.
  - Exactly BIN_W SHIFT cycles. When the counter is 0, go to DONE.
- DONE:
  - out_valid=1. Outputs are registered and stable while out_valid=1 and out_ready=0.
  - If overflow_q=1: bcd_out is all digits 9 and overflow=1. Otherwise bcd_out is the accumulator and overflow=0.
  - On out_ready=1: go to IDLE and drop out_valid the next cycle.
  - out_ready may already be high when DONE is entered; the result is then transferred in that single cycle.
- Latency: out_valid rises on the (BIN_W+1)th rising edge after the accept edge. The accept edge is counted as edge 1, giving 17 edges for BIN_W=16.
- Throughput: one conversion per BIN_W+2 cycles minimum. in_ready is high only in IDLE.
- Width rules:
  - Internal accumulator is 4*DIGITS bits; digits above the true magnitude stay 0.
  - When not overflowed, no carry is lost.
  - Adjust logic for digits above the input's reachable range synthesises away.
- Zero input yields all-zero digits after the full BIN_W cycles (no early exit).

Optional Feature:
- Macro BCD_LEADING_BLANK_EN.
- Defined:
  - In DONE, blank_mask bit k=1 if digit k and every higher digit are 0, for k>=1.
  - Bit 0 is always 0, so the units digit shows.
  - blank_mask is 0 when overflow=1.
  - blank_mask is registered with bcd_out and held under backpressure.
- Undefined: blank_mask is tied to all zeros and no blanking logic is synthesised.

Decomposition:
- Package bcd_pkg:
  - state enum type (IDLE, SHIFT, DONE).
  - BCD_DIGIT_W=4.
  - constant function pow10(n) for MAX_VAL.
  - clog2-based counter width helper.
- Sub-module bcd_digit_adj: combinational 4-bit add-3-if-≥5. The top level instantiates it DIGITS times in a generate loop.

Test Plan:
- Max value: BIN_W=16, DIGITS=5, numero_in=65535 → bcd_out digits 6,5,5,3,5, overflow=0; out_valid on the 17th edge after accept.
- Overflow saturation: DIGITS=4, numero_in=12345 → bcd_out=16'h9999, overflow=1; numero_in=9999 → 16'h9999, overflow=0.
- Zero and backpressure: numero_in=0 with out_ready=0 for 10 cycles → out_valid stays 1, bcd_out=0 stable. Then out_ready=1 → out_valid=0 next cycle and in_ready=1.
- Busy rejection: assert in_valid=1 with numero_in=77 during SHIFT of value 1234 → result is 1234; 77 is not accepted until in_ready=1.
- Reset mid-conversion: drop rst_n 5 cycles into a conversion of 4321 → outputs return to reset values immediately. After release, accept 8 → bcd_out=8 with the correct latency.
- Blanking (macro defined): numero_in=42, DIGITS=5 → blank_mask=5'b11100. numero_in=0 → blank_mask=5'b11110.
